// File: rtl/la_capture_qualifier.sv
// Capture qualifier: registers raw probe data and emits a qualified sample stream
// (change or hold-timer expiry) with a counted pattern trigger.
//
//   state | meaning
//   IDLE  | disarmed, no samples qualified
//   PRIME | latch shadow config, clear trigger/counters, force one sample
//   RUN   | qualify on data change or hold expiry, evaluate trigger
module la_capture_qualifier #(
  parameter int DW = 16,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] trig_mask,
  input  logic [DW-1:0] trig_value,
  input  logic [7:0]    trig_count,
  input  logic [TW-1:0] hold_max,
  output logic [DW-1:0] dout,
  output logic          cqual,
  output logic [TW-1:0] delta,
  output logic          trig,
  output logic          trig_seen
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  localparam logic [TW-1:0] HOLD_SAT = '1;

  state_t        state, state_nxt;
  logic [DW-1:0] s1;
  logic [DW-1:0] mask_sh, value_sh;
  logic [7:0]    count_sh;
  logic [TW-1:0] hold_sh;
  logic [TW-1:0] hold_cnt;
  logic [7:0]    match_cnt;

  logic          is_prime, is_run;
  logic [DW-1:0] mask_eff, value_eff;
  logic [7:0]    count_eff, count_tgt, match_cnt_eff;
  logic          seen_eff;
  logic          hold_hit, changed, qual, match, fire;
  logic [TW-1:0] delta_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = PRIME;
      PRIME:   state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (!en) state_nxt = IDLE;
  end

  // During PRIME the shadows are still being loaded, so the live inputs stand in for them.
  always_comb begin
    is_prime      = (state == PRIME);
    is_run        = (state == RUN);
    mask_eff      = is_prime ? trig_mask  : mask_sh;
    value_eff     = is_prime ? trig_value : value_sh;
    count_eff     = is_prime ? trig_count : count_sh;
    seen_eff      = is_prime ? 1'b0 : trig_seen;
    match_cnt_eff = is_prime ? 8'd0 : match_cnt;
    count_tgt     = (count_eff == 8'd0) ? 8'd1 : count_eff;
    hold_hit      = is_run && (hold_sh != '0) && (hold_cnt == hold_sh);
    changed       = is_run && (s1 != dout);
    qual          = en && (is_prime || changed || hold_hit);
    match         = ((s1 ^ value_eff) & mask_eff) == '0;
    fire          = qual && match && !seen_eff &&
                    (({1'b0, match_cnt_eff} + 9'd1) == {1'b0, count_tgt});
    delta_nxt     = is_prime ? '0 :
                    (hold_cnt == HOLD_SAT) ? HOLD_SAT : hold_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      mask_sh   <= '0;
      value_sh  <= '0;
      count_sh  <= '0;
      hold_sh   <= '0;
      hold_cnt  <= '0;
      match_cnt <= '0;
      dout      <= '0;
      cqual     <= 1'b0;
      delta     <= '0;
      trig      <= 1'b0;
      trig_seen <= 1'b0;
    end else begin
      s1    <= din;
      cqual <= qual;
      trig  <= fire;

      if (is_prime) begin
        mask_sh   <= trig_mask;
        value_sh  <= trig_value;
        count_sh  <= trig_count;
        hold_sh   <= hold_max;
        match_cnt <= '0;
        trig_seen <= 1'b0;
      end

      if (is_prime || qual) hold_cnt <= '0;
      else if (is_run && hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + TW'(1);

      if (qual) begin
        dout  <= s1;
        delta <= delta_nxt;
      end

      // Counting stops once the trigger has fired, so only one trig per arm.
      if (qual && match && !seen_eff) match_cnt <= match_cnt_eff + 8'd1;
      if (fire) trig_seen <= 1'b1;
    end
  end

endmodule
